// File: rtl/cp0_unit_pkg.sv
// Shared MIPS CP0 definitions: operation codes, register indices, bit positions.
// Also provides the per-register MTC0 write mask used for writes and read bypass.
// Imported by cp0_unit and the pipeline controller.
package cp0_unit_pkg;

    typedef enum logic [1:0] {
        CP_NONE  = 2'd0,
        CP_STORE = 2'd1,   // MTC0
        CP_ERET  = 2'd2,
        CP_RSVD  = 2'd3    // decodes as NONE
    } cp_oper_t;

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;
    localparam logic [4:0] REG_EBASE  = 5'd15;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_IP   = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TAKE,
        ST_HANDLER,
        ST_RET
    } cp0_state_t;

    // Registers that MTC0 can change; CAUSE and unmapped indices are not writable.
    function automatic logic cp0_writable(input logic [4:0] idx);
        return (idx == REG_STATUS) || (idx == REG_EPC) || (idx == REG_EBASE);
    endfunction

    // Value a register holds after an MTC0 of d.
    function automatic logic [31:0] cp0_wmask(input logic [4:0] idx, input logic [31:0] d);
        logic [31:0] v;
        v = '0;
        if (idx == REG_STATUS) begin
            v[STATUS_IE]  = d[STATUS_IE];
            v[STATUS_EXL] = d[STATUS_EXL];
        end else if (idx == REG_EPC) begin
            v = d;
        end else if (idx == REG_EBASE) begin
            v = {d[31:2], 2'b00};
        end
        return v;
    endfunction

endpackage

// File: rtl/cp0_unit_irq_sync.sv
// irq_sync: 2-flop synchronizer for the async interrupt level plus rising-edge detect.
// Ports: clk, rst_n, async_in (raw level), rise (one-cycle pulse on synchronized 0->1).
// Latency: rise asserts after the second clock edge that samples async_in high.
module irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS CP0 subset (STATUS/CAUSE/EPC/EBASE), MTC0/MFC0, interrupt take and ERET.
// Ports: cp_oper/cp_en operation, addr_r/data_r read, addr_w/data_w write, ret_addr,
//        ir_in/ir_accept interrupt, jump_en/jump_addr registered one-cycle redirect.
module cp0_unit
    import cp0_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  cp_oper,
    input  logic        cp_en,
    input  logic [4:0]  addr_r,
    output logic [31:0] data_r,
    input  logic [4:0]  addr_w,
    input  logic [31:0] data_w,
    input  logic [31:0] ret_addr,
    input  logic        ir_in,
    input  logic        ir_accept,
    output logic        jump_en,
    output logic [31:0] jump_addr
);

    cp0_state_t  state;
    cp0_state_t  state_nxt;
    logic        ie;
    logic        exl;
    logic        ip;
    logic [31:0] epc;
    logic [31:0] ebase;

    logic irq_rise;
    logic store;
    logic eret;
    logic eret_ok;
    logic take;

    irq_sync u_irq_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ir_in),
        .rise     (irq_rise)
    );

    assign store   = cp_en && (cp_oper == CP_STORE);
    assign eret    = cp_en && (cp_oper == CP_ERET);
    // ERET only acts while idle or in the handler; redirect cycles ignore it.
    assign eret_ok = eret && ((state == ST_IDLE) || (state == ST_HANDLER));
    // An edge arriving this cycle counts as pending so the take can happen in the
    // same edge that would otherwise latch IP.
    assign take    = (state == ST_IDLE) && !eret && (ip || irq_rise) &&
                     ie && !exl && ir_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Redirect outputs decode state and registers only: no input reaches them.
    always_comb begin
        state_nxt = state;
        jump_en   = 1'b0;
        jump_addr = '0;
        case (state)
            ST_IDLE: begin
                if (eret_ok)   state_nxt = ST_RET;
                else if (take) state_nxt = ST_TAKE;
            end
            ST_TAKE: begin
                jump_en   = 1'b1;
                jump_addr = ebase;
                state_nxt = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (eret_ok) state_nxt = ST_RET;
            end
            ST_RET: begin
                jump_en   = 1'b1;
                jump_addr = epc;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie    <= 1'b0;
            exl   <= 1'b0;
            ip    <= 1'b0;
            epc   <= '0;
            ebase <= '0;
        end else begin
            if (store && (addr_w == REG_STATUS)) ie <= data_w[STATUS_IE];

            // ERET beats the take, which beats a software write of EXL.
            if (eret_ok)                              exl <= 1'b0;
            else if (take)                            exl <= 1'b1;
            else if (store && (addr_w == REG_STATUS)) exl <= data_w[STATUS_EXL];

            // Taking the interrupt consumes both a latched IP and a same-cycle edge.
            if (take)          ip <= 1'b0;
            else if (irq_rise) ip <= 1'b1;

            if (take)                              epc <= ret_addr;
            else if (store && (addr_w == REG_EPC)) epc <= data_w;

            if (store && (addr_w == REG_EBASE)) ebase <= cp0_wmask(REG_EBASE, data_w);
        end
    end

    // MFC0 read with same-cycle MTC0 bypass for writable registers.
    always_comb begin
        data_r = '0;
        case (addr_r)
            REG_STATUS: begin
                data_r[STATUS_IE]  = ie;
                data_r[STATUS_EXL] = exl;
            end
            REG_CAUSE: data_r[CAUSE_IP] = ip;
            REG_EPC:   data_r = epc;
            REG_EBASE: data_r = ebase;
            default:   data_r = '0;
        endcase
        if (store && (addr_w == addr_r) && cp0_writable(addr_r)) begin
            data_r = cp0_wmask(addr_r, data_w);
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Testbench for cp0_unit: register-map vector table, directed interrupt/ERET/reset
// sequences, then randomized traffic checked every cycle against a behavioural model.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cp_oper;
    logic        cp_en;
    logic [4:0]  addr_r;
    logic [31:0] data_r;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic [31:0] ret_addr;
    logic        ir_in;
    logic        ir_accept;
    logic        jump_en;
    logic [31:0] jump_addr;

    int checks = 0;
    int errors = 0;

    cp0_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cp_oper   (cp_oper),
        .cp_en     (cp_en),
        .addr_r    (addr_r),
        .data_r    (data_r),
        .addr_w    (addr_w),
        .data_w    (data_w),
        .ret_addr  (ret_addr),
        .ir_in     (ir_in),
        .ir_accept (ir_accept),
        .jump_en   (jump_en),
        .jump_addr (jump_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_TAKE = 1, P_HANDLER = 2, P_RET = 3;
    bit          m_ie, m_exl, m_ip;
    logic [31:0] m_epc, m_ebase;
    int          m_phase;
    bit          hist [3];   // ir_in as sampled at the last three edges, [0] newest

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_ip = 0; m_epc = 0; m_ebase = 0; m_phase = P_IDLE;
        for (int i = 0; i < 3; i++) hist[i] = 0;
    endtask

    function automatic logic [31:0] m_data();
        logic [31:0] v;
        v = 0;
        if (cp_en && cp_oper == 2'd1 && addr_w == addr_r) begin
            if (addr_r == 5'd12) return data_w & 32'h3;
            if (addr_r == 5'd14) return data_w;
            if (addr_r == 5'd15) return data_w & 32'hffff_fffc;
        end
        case (addr_r)
            5'd12:   v = {30'b0, m_exl, m_ie};
            5'd13:   v = m_ip ? 32'h0000_0400 : 32'h0;
            5'd14:   v = m_epc;
            5'd15:   v = m_ebase;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic model_step();
        bit store, eret, rise, eret_ok, take;
        store   = cp_en && cp_oper == 2'd1;
        eret    = cp_en && cp_oper == 2'd2;
        rise    = hist[1] && !hist[2];   // synchronized level is two samples old
        eret_ok = eret && (m_phase == P_IDLE || m_phase == P_HANDLER);
        take    = m_phase == P_IDLE && !eret && (m_ip || rise) && m_ie && !m_exl && ir_accept;
        if (store) begin
            case (addr_w)
                5'd12: begin m_ie = data_w[0]; m_exl = data_w[1]; end
                5'd14: m_epc = data_w;
                5'd15: m_ebase = data_w & 32'hffff_fffc;
                default: ;
            endcase
        end
        if (take) begin m_epc = ret_addr; m_exl = 1; end
        if (eret_ok) m_exl = 0;
        if (take) m_ip = 0;
        else if (rise) m_ip = 1;
        case (m_phase)
            P_IDLE:    m_phase = eret_ok ? P_RET : (take ? P_TAKE : P_IDLE);
            P_TAKE:    m_phase = P_HANDLER;
            P_HANDLER: m_phase = eret_ok ? P_RET : P_HANDLER;
            default:   m_phase = P_IDLE;
        endcase
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = ir_in;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic        obs_j;
    logic [31:0] obs_a, obs_d;

    // One clock: compare outputs at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        logic [31:0] e_a;
        logic        e_j;
        @(negedge clk);
        e_j   = (m_phase == P_TAKE || m_phase == P_RET);
        e_a   = (m_phase == P_TAKE) ? m_ebase : (m_phase == P_RET) ? m_epc : 32'h0;
        obs_j = jump_en; obs_a = jump_addr; obs_d = data_r;
        chk("model_data_r", obs_d, m_data());
        chk("model_jump_en", {31'b0, obs_j}, {31'b0, e_j});
        chk("model_jump_addr", obs_a, e_a);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_ops();
        cp_en = 0; cp_oper = 0; addr_w = 0; data_w = 0;
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  op;
        logic [4:0]  ar;
        logic [4:0]  aw;
        logic [31:0] dw;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [19];

    initial begin
        int first, pulses;

        vecs[0]  = '{1'b0, 2'd0, 5'd12, 5'd0,  32'h0,         32'h0};
        vecs[1]  = '{1'b1, 2'd1, 5'd15, 5'd15, 32'h0000_0403, 32'h0000_0400};
        vecs[2]  = '{1'b0, 2'd0, 5'd15, 5'd0,  32'h0,         32'h0000_0400};
        vecs[3]  = '{1'b1, 2'd1, 5'd14, 5'd14, 32'hdead_beef, 32'hdead_beef};
        vecs[4]  = '{1'b0, 2'd0, 5'd14, 5'd0,  32'h0,         32'hdead_beef};
        vecs[5]  = '{1'b1, 2'd1, 5'd13, 5'd13, 32'hffff_ffff, 32'h0};
        vecs[6]  = '{1'b0, 2'd0, 5'd13, 5'd0,  32'h0,         32'h0};
        vecs[7]  = '{1'b1, 2'd1, 5'd7,  5'd7,  32'h1234_5678, 32'h0};
        vecs[8]  = '{1'b0, 2'd0, 5'd7,  5'd0,  32'h0,         32'h0};
        vecs[9]  = '{1'b1, 2'd1, 5'd12, 5'd12, 32'hffff_fffc, 32'h0};
        vecs[10] = '{1'b0, 2'd0, 5'd12, 5'd0,  32'h0,         32'h0};
        vecs[11] = '{1'b1, 2'd3, 5'd14, 5'd14, 32'h0000_5555, 32'hdead_beef};
        vecs[12] = '{1'b0, 2'd1, 5'd14, 5'd14, 32'h0000_1234, 32'hdead_beef};
        vecs[13] = '{1'b1, 2'd1, 5'd14, 5'd15, 32'h0000_0800, 32'hdead_beef};
        vecs[14] = '{1'b0, 2'd0, 5'd15, 5'd0,  32'h0,         32'h0000_0800};
        vecs[15] = '{1'b1, 2'd1, 5'd15, 5'd15, 32'h0000_0400, 32'h0000_0400};
        vecs[16] = '{1'b0, 2'd0, 5'd15, 5'd0,  32'h0,         32'h0000_0400};
        vecs[17] = '{1'b1, 2'd1, 5'd12, 5'd12, 32'h0000_0001, 32'h0000_0001};
        vecs[18] = '{1'b0, 2'd0, 5'd12, 5'd0,  32'h0,         32'h0000_0001};

        rst_n = 0; idle_ops(); addr_r = 0; ret_addr = 0; ir_in = 0; ir_accept = 1;
        model_reset();
        #12;
        chk("rst_jump_en", {31'b0, jump_en}, 32'h0);
        chk("rst_jump_addr", jump_addr, 32'h0);
        for (int a = 12; a < 16; a++) begin
            addr_r = 5'(a); #1;
            chk("rst_data_r", data_r, 32'h0);
        end
        @(posedge clk); #1 rst_n = 1;

        // Register map and bypass table.
        for (int i = 0; i < 19; i++) begin
            cp_en = vecs[i].en; cp_oper = vecs[i].op; addr_r = vecs[i].ar;
            addr_w = vecs[i].aw; data_w = vecs[i].dw;
            cycle();
            chk($sformatf("vec%0d_data_r", i), obs_d, vecs[i].exp);
            chk($sformatf("vec%0d_no_jump", i), {31'b0, obs_j}, 32'h0);
        end
        idle_ops();

        // Interrupt take: IE=1, redirect to EBASE three edges after ir_in rises.
        ret_addr = 32'h0000_0120; ir_accept = 1; ir_in = 1;
        first = -1; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (obs_j) begin
                pulses++;
                if (first < 0) begin first = i; chk("take_addr", obs_a, 32'h0000_0400); end
            end
        end
        chk("take_latency", 32'(first), 32'd3);
        chk("take_pulses", 32'(pulses), 32'd1);
        addr_r = 14; cycle(); chk("take_epc", obs_d, 32'h0000_0120);
        addr_r = 12; cycle(); chk("take_status", obs_d, 32'h0000_0003);
        addr_r = 13; cycle(); chk("take_cause", obs_d, 32'h0);

        // Second edge while in the handler: latched, not taken.
        ir_in = 0; repeat (3) cycle();
        ir_in = 1; pulses = 0;
        for (int i = 0; i < 5; i++) begin cycle(); if (obs_j) pulses++; end
        chk("handler_no_jump", 32'(pulses), 32'd0);
        chk("handler_ip_set", obs_d, 32'h0000_0400);

        // ERET: return to EPC, one idle cycle, then the pending interrupt is taken.
        cp_en = 1; cp_oper = 2; cycle(); idle_ops();
        addr_r = 12;
        cycle(); chk("ret_jump", {31'b0, obs_j}, 32'h1); chk("ret_addr", obs_a, 32'h0000_0120);
        cycle(); chk("gap_no_jump", {31'b0, obs_j}, 32'h0); chk("ret_exl_clear", obs_d, 32'h1);
        cycle(); chk("retake_jump", {31'b0, obs_j}, 32'h1); chk("retake_addr", obs_a, 32'h0000_0400);
        cp_en = 1; cp_oper = 2; cycle(); idle_ops();
        cycle(); chk("ret2_jump", {31'b0, obs_j}, 32'h1);
        cycle();

        // ir_accept low holds the pending interrupt.
        ir_accept = 0; ret_addr = 32'h0000_0200; addr_r = 13;
        ir_in = 0; repeat (3) cycle();
        ir_in = 1; pulses = 0;
        for (int i = 0; i < 10; i++) begin cycle(); if (obs_j) pulses++; end
        chk("hold_no_jump", 32'(pulses), 32'd0);
        chk("hold_ip", obs_d, 32'h0000_0400);
        ir_accept = 1;
        cycle(); chk("accept_edge_no_jump", {31'b0, obs_j}, 32'h0);
        cycle(); chk("accept_take", {31'b0, obs_j}, 32'h1);
        addr_r = 14; cycle(); chk("accept_epc", obs_d, 32'h0000_0200);

        // Reset pulse in the handler.
        #1 rst_n = 0; model_reset();
        #1;
        chk("mid_rst_jump_en", {31'b0, jump_en}, 32'h0);
        chk("mid_rst_jump_addr", jump_addr, 32'h0);
        for (int a = 12; a < 16; a++) begin
            addr_r = 5'(a); #1;
            chk("mid_rst_data_r", data_r, 32'h0);
        end
        @(posedge clk); #1 rst_n = 1;
        addr_r = 13; pulses = 0;
        for (int i = 0; i < 8; i++) begin cycle(); if (obs_j) pulses++; end
        chk("post_rst_no_jump", 32'(pulses), 32'd0);
        chk("post_rst_ip", obs_d, 32'h0000_0400);
        cp_en = 1; cp_oper = 1; addr_w = 12; data_w = 1;
        first = -1;
        for (int i = 0; i < 5; i++) begin
            cycle(); idle_ops();
            if (obs_j && first < 0) begin first = i; chk("post_rst_take_addr", obs_a, 32'h0); end
        end
        chk("post_rst_take_latency", 32'(first), 32'd2);
        cp_en = 1; cp_oper = 2; cycle(); idle_ops(); cycle(); cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            cp_en     = ($urandom_range(0, 3) != 0);
            cp_oper   = 2'($urandom_range(0, 3));
            addr_w    = ($urandom_range(0, 3) != 0) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            addr_r    = ($urandom_range(0, 3) != 0) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            data_w    = $urandom;
            ret_addr  = $urandom;
            ir_accept = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) ir_in = ~ir_in;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge system clock; rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have cp_oper in 2: CP0 operation from the decoder. Codes: NONE=0, STORE=1 (MTC0), ERET=2; 3 is reserved and treated as NONE.
REQ-003 SHALL have cp_en in 1: qualifies cp_oper; the pipeline stage holding the operation is valid and not stalled.
REQ-004 SHALL have addr_r in 5: CP0 read register index (rd field).
REQ-005 SHALL have data_r out 32: CP0 read data for MFC0 forwarding.
REQ-006 SHALL have addr_w in 5 and data_w in 32: MTC0 destination index and write data.
REQ-007 SHALL have ret_addr in 32: PC to save in EPC when an interrupt is taken.
REQ-008 SHALL have ir_in in 1: external interrupt request, asynchronous, level.
REQ-009 SHALL have ir_accept in 1: the pipeline can be redirected this cycle.
REQ-010 SHALL have jump_en out 1: one-cycle redirect pulse to the controller.
REQ-011 SHALL have jump_addr out 32: redirect target, valid while jump_en=1.

Function
REQ-012 Register map SHALL be:
- STATUS=12: bit0 IE, bit1 EXL; other bits read 0.
- CAUSE=13: bit10 IP, read-only to MTC0; other bits read 0.
- EPC=14: 32 bits, R/W.
- EBASE=15: 32 bits, R/W; bits[1:0] forced 0.
- Any other index reads 0 and ignores writes.
REQ-013 MTC0 (cp_en & cp_oper=STORE) SHALL write data_w to addr_w at the clock edge.
REQ-014 data_r SHALL be combinational from addr_r. When an MTC0 to the same index is active that cycle, data_r SHALL return the masked data_w (bypass).
REQ-015 ir_in SHALL pass through a 2-flop synchronizer. A rising edge of the synchronized level SHALL set CAUSE.IP (sticky).
REQ-016 State machine SHALL have states IDLE, TAKE, HANDLER, RET.
REQ-017 IDLE->TAKE SHALL occur when IP & IE & ~EXL & ir_accept & no ERET this cycle. At that edge: EPC<=ret_addr, EXL<=1, IP<=0.
REQ-018 In TAKE, jump_en=1 and jump_addr=EBASE for exactly one cycle; the next state SHALL be HANDLER.
REQ-019 HANDLER SHALL hold until cp_en & cp_oper=ERET. At that edge: EXL<=0, next state RET.
REQ-020 In RET, jump_en=1 and jump_addr=EPC for exactly one cycle; the next state SHALL be IDLE.
REQ-021 ERET in IDLE SHALL also go to RET and clear EXL; ERET in TAKE or RET SHALL be ignored.
REQ-022 Outside TAKE/RET, jump_en=0 and jump_addr=0.
REQ-023 Priority in the same cycle SHALL be: ERET > interrupt take > MTC0 on the STATUS.EXL bit. An MTC0 to EPC on the take edge SHALL lose to the ret_addr capture.
REQ-024 An interrupt edge arriving while EXL=1 SHALL set IP and be taken only after returning to IDLE with IE=1. At least one IDLE cycle SHALL separate RET from the next TAKE.
REQ-025 ir_accept=0 SHALL hold a pending interrupt indefinitely without losing it.
REQ-026 The latency from the ir_in edge to jump_en SHALL be ≥3 cycles: 2 synchronizer cycles plus the TAKE registration.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=IDLE and zero STATUS, CAUSE, EPC, EBASE and the synchronizer flops. While rst_n=0, jump_en=0, jump_addr=0 and data_r follows the zeroed registers.
REQ-028 Reset deassertion mid-operation (TAKE/HANDLER) SHALL resume from IDLE with no pending interrupt.

Structure
REQ-029 cp_oper codes, register indices and STATUS/CAUSE bit positions SHALL live in the shared MIPS define package used by the controller.
REQ-030 The 2-flop synchronizer plus edge detector SHALL be one sub-module, irq_sync.
REQ-031 jump_en and jump_addr SHALL be registered (decoded from state and registers only), with no combinational path from any input.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- MTC0 EBASE=0x00000400 with addr_r=15 in the same cycle: data_r=0x00000400 (bypass). Next cycle: still 0x00000400.
- STATUS.IE=1, ret_addr=0x00000120, ir_accept=1, ir_in rises: jump_en pulses one cycle, 3 cycles later, with jump_addr=0x00000400. EPC=0x120, EXL=1, IP=0.
- ERET in HANDLER: next cycle jump_en=1 with jump_addr=0x00000120; EXL=0; state returns to IDLE.
- Second ir_in edge during HANDLER: no jump. After RET, one IDLE cycle, then TAKE.
- ir_accept=0 for 10 cycles with IP=1: no jump_en. ir_accept rises: TAKE on the next edge.
- rst_n pulsed low in HANDLER: all registers 0, jump_en=0 immediately. After release, an interrupt is ignored until IE is set again.
